// File: rtl/fft_bf_sequencer.sv
// Radix-2 FFT butterfly sequencer: fetch two operands, hand them to the butterfly unit,
// write results to the ping-pong bank, step the address generator. Optional FFT_SEQ_SCALE_EN halves results.
module fft_bf_sequencer #(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N),
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] idx_a,
  input  logic [ADDR_WIDTH-1:0] idx_b,
  input  logic                  done_stage,
  input  logic                  done_fft,
  output logic                  next_step,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_bank,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_bank,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  bf_valid,
  output logic [DATA_W-1:0]     bf_a,
  output logic [DATA_W-1:0]     bf_b,
  input  logic                  bf_done,
  input  logic [DATA_W-1:0]     bf_ra,
  input  logic [DATA_W-1:0]     bf_rb,
  output logic                  busy,
  output logic                  done,
  output logic                  result_bank
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_BF, S_WR_A, S_WR_B, S_STEP, S_SYNC, S_DONE
  } state_t;

  state_t                  state;
  logic                    bank_sel;
  logic                    bank_nx;
  logic [ADDR_WIDTH-1:0]   lat_a, lat_b;
  logic [DATA_W-1:0]       op_a, res_b;

  assign bank_nx = bank_sel ^ done_stage;

  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] x);
`ifdef FFT_SEQ_SCALE_EN
    logic signed [DATA_W/2-1:0] re, im;
    re = x[DATA_W-1:DATA_W/2];
    im = x[DATA_W/2-1:0];
    return {re >>> 1, im >>> 1};
`else
    return x;
`endif
  endfunction

  // Outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      bank_sel    <= 1'b0;
      lat_a       <= '0;
      lat_b       <= '0;
      op_a        <= '0;
      res_b       <= '0;
      next_step   <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      rd_bank     <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_bank     <= 1'b0;
      wr_data     <= '0;
      bf_valid    <= 1'b0;
      bf_a        <= '0;
      bf_b        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_bank <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          lat_a   <= idx_a;
          lat_b   <= idx_b;
          rd_en   <= 1'b1;
          rd_addr <= idx_a;
          rd_bank <= bank_sel;
          wr_bank <= ~bank_sel;
          busy    <= 1'b1;
          state   <= S_RD_A;
        end
        S_RD_A: begin
          rd_addr <= lat_b;
          state   <= S_RD_B;
        end
        S_RD_B: begin
          op_a  <= rd_data;
          rd_en <= 1'b0;
          state <= S_CAP_B;
        end
        S_CAP_B: begin
          bf_a     <= op_a;
          bf_b     <= rd_data;
          bf_valid <= 1'b1;
          state    <= S_BF;
        end
        // The butterfly unit may stall indefinitely; no watchdog here.
        S_BF: if (bf_done) begin
          bf_valid <= 1'b0;
          res_b    <= bf_rb;
          wr_en    <= 1'b1;
          wr_addr  <= lat_a;
          wr_data  <= scale(bf_ra);
          state    <= S_WR_A;
        end
        S_WR_A: begin
          wr_addr <= lat_b;
          wr_data <= scale(res_b);
          state   <= S_WR_B;
        end
        S_WR_B: begin
          wr_en     <= 1'b0;
          next_step <= 1'b1;
          state     <= S_STEP;
        end
        S_STEP: begin
          next_step <= 1'b0;
          state     <= S_SYNC;
        end
        // Generator outputs have settled one cycle after next_step.
        S_SYNC: begin
          bank_sel <= bank_nx;
          if (done_fft) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            result_bank <= bank_nx;
            state       <= S_DONE;
          end else begin
            lat_a   <= idx_a;
            lat_b   <= idx_b;
            rd_en   <= 1'b1;
            rd_addr <= idx_a;
            rd_bank <= bank_nx;
            wr_bank <= ~bank_nx;
            state   <= S_RD_A;
          end
        end
        S_DONE: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
